// File: rtl/gcd_pkg.sv
// Shared definitions for the round-robin GCD arbiter: FSM encoding, default
// operand width and the round-robin requester search.
package gcd_pkg;

    localparam int W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Search req (up to 8 requesters) starting at last+1, wrapping modulo n.
    // Returns {found, index}; the nearest requester after 'last' wins.
    function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] last,
                                           input logic [3:0] n);
        logic [3:0] r;
        logic [3:0] idx;
        r = 4'b0;
        for (int k = 8; k >= 1; k--) begin
            // last < n and k <= n, so one wrap subtraction is enough
            idx = {1'b0, last} + 4'(k);
            if (idx >= n) idx = idx - n;
            if ((4'(k) <= n) && req[idx[2:0]]) r = {1'b1, idx[2:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/gcd_arbiter_engine.sv
// Subtractive-Euclid GCD engine: one compare/subtract per enabled cycle.
// o_fin flags the terminating check; o_res is updated on that cycle and held.
module gcd_engine #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_step_en,
    output logic         o_fin,
    output logic [W-1:0] o_res
);

    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic [W-1:0] r_res;
    logic         w_term;

    // Zero operand or equal operands end the job; zero checks come first so
    // gcd(0,0)=0 and gcd(0,n)=n fall out of the same compare.
    assign w_term = (r_x == '0) || (r_y == '0) || (r_x == r_y);
    assign o_fin  = i_step_en && w_term;
    assign o_res  = r_res;

    // Operand load on grant, then one Euclid step per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x   <= '0;
            r_y   <= '0;
            r_res <= '0;
        end else if (i_load) begin
            r_x <= i_a;
            r_y <= i_b;
        end else if (i_step_en) begin
            if (r_x == '0)        r_res <= r_y;
            else if (r_y == '0)   r_res <= r_x;
            else if (r_x == r_y)  r_res <= r_x;
            else if (r_x > r_y)   r_x   <= r_x - r_y;
            else                  r_y   <= r_y - r_x;
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD engine among NREQ requesters.
// Optional feature macro GCD_CYCLE_CNT_EN adds a 32-bit 'cycles' output that
// reports the number of RUN cycles the finished job took (saturating).
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
`ifdef GCD_CYCLE_CNT_EN
    output logic [31:0]       cycles,
`endif
    output logic [W-1:0]      result,
    output logic              busy
);

    state_t          r_state;
    logic [2:0]      r_last;
    logic [2:0]      r_owner;
    logic [NREQ-1:0] r_done;
    logic            r_busy;

    logic [7:0]      w_req8;
    logic [3:0]      w_pick;
    logic            w_load;
    logic            w_fin;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic [W-1:0]    w_res;

    assign w_req8 = 8'(req);
    assign w_pick = rr_pick(w_req8, r_last, 4'(NREQ));
    // Reset wins over a grant presented in the same cycle
    assign w_load = (r_state == IDLE) && w_pick[3] && !reset;
    assign grant  = w_load ? (NREQ'(1) << w_pick[2:0]) : '0;
    assign w_a    = a_in[w_pick[2:0]*W +: W];
    assign w_b    = b_in[w_pick[2:0]*W +: W];

    assign done   = r_done;
    assign busy   = r_busy;
    assign result = w_res;

    gcd_engine #(.W(W)) u_engine (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_a       (w_a),
        .i_b       (w_b),
        .i_step_en (r_state == RUN),
        .o_fin     (w_fin),
        .o_res     (w_res)
    );

    // Job FSM: grant in IDLE, iterate in RUN, pulse done for the owner in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= 3'(NREQ - 1);
            r_owner <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= '0;
                    if (w_load) begin
                        r_owner <= w_pick[2:0];
                        r_last  <= w_pick[2:0];
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_fin) begin
                        r_done  <= NREQ'(1) << r_owner;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef GCD_CYCLE_CNT_EN
    logic [31:0] r_cnt;
    logic [31:0] r_cycles;
    logic [31:0] w_cnt_inc;

    assign w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
    assign cycles    = r_cycles;

    // Count RUN cycles of the current job; latch the total alongside the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_cycles <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_cnt <= w_cnt_inc;
            if (w_fin) r_cycles <= w_cnt_inc;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter (NREQ=4, W=16) with a behavioural
// Euclid/round-robin reference model.
module tb_gcd_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] a_in = '0;
    logic [NREQ*W-1:0] b_in = '0;
    wire  [NREQ-1:0]   grant;
    wire  [NREQ-1:0]   done;
    wire  [W-1:0]      result;
    wire               busy;
`ifdef GCD_CYCLE_CNT_EN
    wire  [31:0]       cycles;
`endif

    int checks = 0;
    int errors = 0;
    int opa [NREQ];
    int opb [NREQ];

    gcd_arbiter #(.NREQ(NREQ), .W(W)) dut (
`ifdef GCD_CYCLE_CNT_EN
        .cycles (cycles),
`endif
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .a_in   (a_in),
        .b_in   (b_in),
        .grant  (grant),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Reference: modulo Euclid
    function automatic int model_gcd(input int a, input int b);
        int t;
        while (b != 0) begin t = a % b; a = b; b = t; end
        return a;
    endfunction

    // Reference: RUN cycles = sum of Euclid quotients (one cycle if an operand is 0)
    function automatic int model_k(input int a, input int b);
        int s, t;
        if (a == 0 || b == 0) return 1;
        s = 0;
        while (b != 0) begin s += a / b; t = a % b; a = b; b = t; end
        return s;
    endfunction

    // Reference: next requester after 'last' in circular order
    function automatic int model_next(input logic [NREQ-1:0] p, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (p[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic set_ops(input int i, input int a, input int b);
        a_in[i*W +: W] = W'(a);
        b_in[i*W +: W] = W'(b);
        opa[i] = a;
        opb[i] = b;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; req = '0;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
    endtask

    // Single job on requester i; returns observations only
    task automatic do_job(input int i, input int a, input int b,
                          output logic [NREQ-1:0] g, output int lat,
                          output logic [NREQ-1:0] d, output logic [W-1:0] res,
                          output int busy_bad, output logic [31:0] cyc);
        @(negedge clk); set_ops(i, a, b); req[i] = 1'b1;
        #1 g = grant;
        @(negedge clk); req[i] = 1'b0;
        lat = 1; busy_bad = 0;
        #1;
        while (done == '0 && lat < 5000) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk); #1;
            lat++;
        end
        if (busy !== 1'b1) busy_bad++;
        d = done; res = result;
`ifdef GCD_CYCLE_CNT_EN
        cyc = cycles;
`else
        cyc = 32'd0;
`endif
        if (lat >= 5000) lat = -1;
    endtask

    task automatic test_reset();
        @(negedge clk); req = 4'b0100; #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant_priority got=%b exp=0000", grant); end
        checks++; if (busy !== 1'b0 || done !== 4'b0000 || result !== 16'd0)
            begin errors++; $display("FAIL reset_outputs busy=%b done=%b result=%0d exp 0/0000/0", busy, done, result); end
`ifdef GCD_CYCLE_CNT_EN
        checks++; if (cycles !== 32'd0) begin errors++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
`endif
        req = '0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000)
            begin errors++; $display("FAIL idle_no_req grant=%b busy=%b done=%b exp 0000/0/0000", grant, busy, done); end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g, d; int lat, bb; logic [W-1:0] res; logic [31:0] cyc;
        do_job(0, 48, 18, g, lat, d, res, bb, cyc);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b exp=0001", g); end
        checks++; if (lat != 6) begin errors++; $display("FAIL single_latency got=%0d exp=6", lat); end
        checks++; if (d !== 4'b0001 || res !== 16'd6) begin errors++; $display("FAIL single_done done=%b result=%0d exp 0001/6", d, res); end
        checks++; if (bb != 0) begin errors++; $display("FAIL single_busy low_cycles=%0d exp=0", bb); end
`ifdef GCD_CYCLE_CNT_EN
        checks++; if (cyc !== 32'd5) begin errors++; $display("FAIL single_cycles got=%0d exp=5", cyc); end
`endif
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 4'b0000)
            begin errors++; $display("FAIL single_after busy=%b done=%b exp 0/0000", busy, done); end
    endtask

    task automatic test_zero();
        int za [3] = '{0, 0, 21};
        int zb [3] = '{0, 35, 21};
        int ze [3] = '{0, 35, 21};
        logic [NREQ-1:0] g, d, one; int lat, bb; logic [W-1:0] res; logic [31:0] cyc;
        one = 4'b0001;
        for (int t = 0; t < 3; t++) begin
            do_job(t, za[t], zb[t], g, lat, d, res, bb, cyc);
            checks++;
            if (g !== (one << t) || lat != 2 || d !== (one << t) || res !== W'(ze[t]))
                begin errors++; $display("FAIL zero_case%0d grant=%b lat=%0d done=%b result=%0d exp %b/2/%b/%0d",
                                         t, g, lat, d, res, one << t, one << t, ze[t]); end
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] g, d, one; int lat, bb, i, a, b; logic [W-1:0] res; logic [31:0] cyc;
        one = 4'b0001;
        for (int n = 0; n < 24; n++) begin
            i = int'($urandom_range(NREQ - 1));
            a = int'($urandom_range(400));
            b = int'($urandom_range(400));
            do_job(i, a, b, g, lat, d, res, bb, cyc);
            checks++;
            if (g !== (one << i) || d !== (one << i) || res !== W'(model_gcd(a, b))
                || lat != model_k(a, b) + 1 || bb != 0)
                begin errors++; $display("FAIL random%0d req=%0d a=%0d b=%0d grant=%b done=%b result=%0d lat=%0d exp result=%0d lat=%0d",
                                         n, i, a, b, g, d, res, lat, model_gcd(a, b), model_k(a, b) + 1); end
`ifdef GCD_CYCLE_CNT_EN
            checks++; if (cyc !== 32'(model_k(a, b))) begin errors++; $display("FAIL random_cycles%0d got=%0d exp=%0d", n, cyc, model_k(a, b)); end
`endif
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] clr, one, pend;
        int ng, nd, lastc, mlast, e;
        int owners[$];
        one = 4'b0001;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_ops(i, 12, 8);
        req = 4'hF; pend = 4'hF; mlast = NREQ - 1;
        ng = 0; nd = 0; clr = '0; lastc = 0;
        for (int c = 0; c < 100 && nd < 4; c++) begin
            if (c > 0) begin @(negedge clk); req = req & ~clr; clr = '0; end
            #1;
            if (grant !== '0) begin
                e = model_next(pend, mlast);
                checks++;
                if (e < 0 || grant !== (one << e)) begin errors++; $display("FAIL rr_grant%0d got=%b exp_idx=%0d", ng, grant, e); end
                if (ng > 0) begin
                    checks++;
                    if (c - lastc != model_k(12, 8) + 2) begin errors++; $display("FAIL rr_spacing%0d got=%0d exp=%0d", ng, c - lastc, model_k(12, 8) + 2); end
                end
                if (e >= 0) begin pend[e] = 1'b0; mlast = e; owners.push_back(e); end
                lastc = c; clr = grant; ng++;
            end
            if (done !== '0) begin
                checks++;
                if (owners.size() == 0) begin errors++; $display("FAIL rr_done%0d got=%b exp=none", nd, done); end
                else begin
                    e = owners.pop_front();
                    if (done !== (one << e) || result !== 16'd4)
                        begin errors++; $display("FAIL rr_done%0d done=%b result=%0d exp %b/4", nd, done, result, one << e); end
                end
                nd++;
            end
        end
        checks++; if (ng != 4 || nd != 4) begin errors++; $display("FAIL rr_count grants=%0d dones=%0d exp 4/4", ng, nd); end
        req = '0;
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] clr, one;
        int ng, nd, mlast, e, seq;
        int owners[$];
        one = 4'b0001;
        do_reset();
        @(negedge clk);
        set_ops(0, 10, 4); set_ops(2, 9, 6);
        req = 4'b0001; mlast = NREQ - 1;
        ng = 0; nd = 0; clr = '0; seq = 0;
        for (int c = 0; c < 200 && nd < 3; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (ng >= 3) req = '0; else req = req & ~(clr & 4'b1110);
                clr = '0;
                if (c == 2) req[2] = 1'b1;
            end
            #1;
            if (grant !== '0) begin
                e = model_next(req, mlast);
                checks++;
                if (e < 0 || grant !== (one << e)) begin errors++; $display("FAIL fair_grant%0d got=%b exp_idx=%0d", ng, grant, e); end
                if (e >= 0) begin mlast = e; owners.push_back(e); end
                seq = seq * 10 + e;
                clr = grant; ng++;
            end
            if (done !== '0) begin
                checks++;
                if (owners.size() == 0) begin errors++; $display("FAIL fair_done%0d got=%b exp=none", nd, done); end
                else begin
                    e = owners.pop_front();
                    if (done !== (one << e) || result !== W'(model_gcd(opa[e], opb[e])))
                        begin errors++; $display("FAIL fair_done%0d done=%b result=%0d exp %b/%0d", nd, done, result, one << e, model_gcd(opa[e], opb[e])); end
                end
                nd++;
            end
        end
        checks++; if (ng != 3 || nd != 3 || seq != 20) begin errors++; $display("FAIL fair_order grants=%0d dones=%0d seq=%0d exp 3/3/020", ng, nd, seq); end
        req = '0;
    endtask

    task automatic test_reset_mid();
        int bad_done, bad_busy, w;
        bad_done = 0; bad_busy = 0;
        @(negedge clk); set_ops(2, 65535, 1); req = 4'b0100; #1;
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL rmid_grant got=%b exp=0100", grant); end
        @(negedge clk); req = 4'b1010; set_ops(1, 14, 21); set_ops(3, 9, 6);
        for (int t = 1; t < 10; t++) begin
            #1;
            if (done !== '0) bad_done++;
            if (busy !== 1'b1) bad_busy++;
            @(negedge clk);
        end
        reset = 1'b1; #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rmid_reset_grant got=%b exp=0000", grant); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (bad_done != 0 || bad_busy != 0) begin errors++; $display("FAIL rmid_running done_cycles=%0d busy_low=%0d exp 0/0", bad_done, bad_busy); end
        checks++; if (busy !== 1'b0 || done !== 4'b0000 || result !== 16'd0)
            begin errors++; $display("FAIL rmid_after busy=%b done=%b result=%0d exp 0/0000/0", busy, done, result); end
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rmid_pointer got=%b exp=0010", grant); end
        @(negedge clk); req[1] = 1'b0;
        w = 0; #1;
        while (done === '0 && w < 100) begin @(negedge clk); #1; w++; end
        checks++; if (done !== 4'b0010 || result !== 16'd7) begin errors++; $display("FAIL rmid_job1 done=%b result=%0d exp 0010/7", done, result); end
        @(negedge clk); #1;
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL rmid_next_grant got=%b exp=1000", grant); end
        @(negedge clk); req = '0;
        w = 0; #1;
        while (done === '0 && w < 100) begin @(negedge clk); #1; w++; end
        checks++; if (done !== 4'b1000 || result !== 16'd3) begin errors++; $display("FAIL rmid_job3 done=%b result=%0d exp 1000/3", done, result); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_random();
        test_round_robin();
        test_fairness();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
- Shares one subtractive-Euclid GCD engine among NREQ requesters, using round-robin arbitration.
- Each requester presents an operand pair and holds req; the arbiter grants one requester, runs the engine, then returns the result with a one-hot done pulse.
- Sits between multi-operand sequencers (e.g. three-operand chains) and the shared datapath, replacing per-client GCD instances.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 16, operand/result width in bits

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  request per requester; level, held until granted
- a_in  input  NREQ*W  operand A per requester, requester i at bits [i*W +: W]
- b_in  input  NREQ*W  operand B per requester, same packing
- grant  output  NREQ  one-hot, one-cycle pulse; operands of granted requester sampled this cycle
- done  output  NREQ  one-hot, one-cycle pulse; result valid for that requester
- result  output  W  GCD result; valid when |done, held until next done
- busy  output  1  high from the cycle after grant through the done cycle

Behaviour:
- All state is updated only on the rising edge of clk; reset is synchronous and active-high.
- Reset values: grant=0, done=0, result=0, busy=0, FSM=IDLE, X=Y=0, rr pointer last=NREQ-1 (requester 0 is first priority).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req!=0, grant is asserted combinationally to the first set req bit, searching from last+1 with wrap-around modulo NREQ.
  - On that edge: X<=a_in[g], Y<=b_in[g], owner<=g, last<=g, FSM->RUN.
  - If req==0, stay in IDLE with grant=0.
- RUN: one comparison per cycle, evaluated in this order:
  - X==0: result<=Y, go to DONE.
  - else Y==0: result<=X, go to DONE.
  - else X==Y: result<=X, go to DONE.
  - else X>Y: X<=X-Y.
  - else: Y<=Y-X.
  - Subtraction is W-bit unsigned and cannot underflow.
- DONE: done[owner]=1 for exactly this cycle, busy=1; then FSM->IDLE. No grant is issued in DONE.
- Latency:
  - Grant at cycle T; RUN occupies T+1..T+k, where k = number of engine steps including the terminating check; done at T+k+1.
  - Earliest next grant is T+k+2.
- gcd(0,0)=0 (X==0 branch returns Y=0). gcd(0,n)=n. gcd(n,n)=n in 1 RUN cycle.
- Worst case k = 2^W-1 cycles, e.g. (65535,1) at W=16. There is no timeout.
- Requesters:
  - Must keep req and operands stable until grant.
  - Should deassert req in the cycle after grant. A req still high in IDLE is treated as a new job.
  - Changes to a_in/b_in after grant have no effect on the running job.
- Fairness: a requester that holds req is granted within NREQ jobs.
- Reset in any state aborts the job immediately: no done pulse, result=0, pointer back to NREQ-1.
- Reset has priority over grant in the same cycle.

Optional Feature:
- Macro: GCD_CYCLE_CNT_EN.
- Defined:
  - Adds output port cycles, 32 bits, driven by a counter cleared at grant and incremented on each RUN cycle.
  - cycles is latched with the result and valid while |done; reset value 0; the counter saturates at 2^32-1.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package gcd_pkg holds:
  - FSM state enum (IDLE, RUN, DONE) as 2-bit localparams
  - default W=16
  - a function for the round-robin next-index search
- Sub-module gcd_engine (X/Y registers, compare/subtract step, result register):
  - interface: load, a, b, step_en, fin, res
  - the arbiter owns the FSM, pointer, grant/done and busy.

Test Plan:
- Single requester, req[0] with A=48, B=18 -> grant[0] at T; RUN steps (48,18)->(30,18)->(12,18)->(12,6)->(6,6); done[0] at T+6; result=6.
- Zero operands:
  - (0,0) -> result 0, done at T+2.
  - (0,35) -> 35, done at T+2.
  - (21,21) -> 21, done at T+2.
- Round-robin with all four req raised simultaneously, each with operands (12,8) -> grants in order 0,1,2,3; each done result=4; no two grants less than 4 cycles apart.
- Fairness with req[0] held continuously and req[2] raised during job 0 -> next grant goes to 2 before 0 again.
- Reset mid-RUN: start (65535,1), assert reset at T+10 for 1 cycle -> no done ever; busy=0 and result=0 next cycle; req[1] pending after reset is granted first.
- With GCD_CYCLE_CNT_EN defined, (48,18) -> cycles=5 while done is high.
